// File: rtl/inst_fetch_mem_ctrl.sv
// Instruction-fetch memory responder: four byte reads from a 1-cycle-latency RAM assembled into a
// little-endian word. Optional macro LAST_FETCH_EN adds a one-entry last-fetch buffer.
module inst_fetch_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ram_read,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_ready,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic [7:0]            mem_din
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    RD0   = 3'd2,
    RD1   = 3'd3,
    RD2   = 3'd4,
    RD3   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            byte0_q, byte0_d;
  logic [7:0]            byte1_q, byte1_d;
  logic [7:0]            byte2_q, byte2_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_ready_q, ram_ready_d;
  logic                  mem_wr_q;
  logic                  hit_s;

`ifdef LAST_FETCH_EN
  logic                  buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_tag_q, buf_tag_d;
  logic [DATA_WIDTH-1:0] buf_word_q, buf_word_d;

  assign hit_s = buf_valid_q && (ram_addr == buf_tag_q);
`else
  assign hit_s = 1'b0;
`endif

  // Next-state and datapath: any change of request while a fetch is in flight aborts it.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mem_a_d     = mem_a_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    byte2_d     = byte2_q;
    ram_data_d  = ram_data_q;
    ram_ready_d = 1'b0;
`ifdef LAST_FETCH_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_word_d  = buf_word_q;
`endif
    case (state_q)
      IDLE: begin
        if (ram_read && hit_s) begin
`ifdef LAST_FETCH_EN
          ram_data_d = buf_word_q;
`endif
          ram_ready_d = 1'b1;
          state_d     = DONE;
        end else if (ram_read) begin
          addr_d  = ram_addr;
          mem_a_d = ram_addr;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE, RD0, RD1, RD2, RD3: begin
        if (!ram_read) begin
          state_d = IDLE;
        end else if (ram_addr != addr_q) begin
          addr_d  = ram_addr;
          mem_a_d = ram_addr;
          byte0_d = 8'h00;
          byte1_d = 8'h00;
          byte2_d = 8'h00;
          state_d = ISSUE;
        end else begin
          case (state_q)
            ISSUE: begin
              mem_a_d = addr_q + ADDR_WIDTH'(1);
              state_d = RD0;
            end
            RD0: begin
              byte0_d = mem_din;
              mem_a_d = addr_q + ADDR_WIDTH'(2);
              state_d = RD1;
            end
            RD1: begin
              byte1_d = mem_din;
              mem_a_d = addr_q + ADDR_WIDTH'(3);
              state_d = RD2;
            end
            RD2: begin
              byte2_d = mem_din;
              state_d = RD3;
            end
            RD3: begin
              ram_data_d  = {mem_din, byte2_q, byte1_q, byte0_q};
              ram_ready_d = 1'b1;
              state_d     = DONE;
`ifdef LAST_FETCH_EN
              buf_valid_d = 1'b1;
              buf_tag_d   = addr_q;
              buf_word_d  = {mem_din, byte2_q, byte1_q, byte0_q};
`endif
            end
            default: state_d = IDLE;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      mem_a_q     <= {ADDR_WIDTH{1'b0}};
      byte0_q     <= 8'h00;
      byte1_q     <= 8'h00;
      byte2_q     <= 8'h00;
      ram_data_q  <= {DATA_WIDTH{1'b0}};
      ram_ready_q <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_a_q     <= mem_a_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      byte2_q     <= byte2_d;
      ram_data_q  <= ram_data_d;
      ram_ready_q <= ram_ready_d;
      mem_wr_q    <= 1'b0;
    end
  end

`ifdef LAST_FETCH_EN
  // Last-fetch buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= {ADDR_WIDTH{1'b0}};
      buf_word_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_word_q  <= buf_word_d;
    end
  end
`endif

  assign ram_ready = ram_ready_q;
  assign ram_data  = ram_data_q;
  assign mem_a     = mem_a_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_inst_fetch_mem_ctrl.sv
// Self-checking bench for inst_fetch_mem_ctrl: directed cases plus randomized fetches, aborts and
// back-to-back requests, checked against a transaction-level model (RAM contents + last-fetch buffer).
module tb_inst_fetch_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ram_read;
  logic [31:0] ram_addr;
  logic        ram_ready;
  logic [31:0] ram_data;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_din;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [logic [31:0]];
  bit          buf_valid;
  logic [31:0] buf_tag;
  logic [31:0] buf_word;
  logic [31:0] last_data;

  always #5 clk = ~clk;

  inst_fetch_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ram_read(ram_read), .ram_addr(ram_addr),
    .ram_ready(ram_ready), .ram_data(ram_data), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_din(mem_din)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = a * 32'h9E3779B1;
    return h[31:24] ^ h[7:0];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
`ifdef LAST_FETCH_EN
    return buf_valid && (buf_tag == a);
`else
    return 1'b0;
`endif
  endfunction

  // Byte-wide synchronous RAM, one cycle of read latency.
  always @(posedge clk) mem_din <= mem_byte(mem_a);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request address a; pre = edges the controller will ignore first (request raised in DONE).
  task automatic fetch(input logic [31:0] a, input int pre, input bit may_hit);
    logic [31:0] trace[$];
    logic [31:0] a_before;
    logic [31:0] exp_w;
    bit          hit;
    int          exp_n;
    int          n;
    hit      = may_hit && model_hit(a);
    exp_n    = pre + (hit ? 1 : 6);
    exp_w    = hit ? buf_word : word_at(a);
    a_before = mem_a;
    ram_read = 1'b1;
    ram_addr = a;
    n        = 0;
    do begin
      tick();
      n++;
      trace.push_back(mem_a);
    end while (!ram_ready && n < 20);
    check_eq("latency", n, exp_n);
    check_eq("data", ram_data, exp_w);
    if (n == exp_n) begin
      if (hit) begin
        check_eq("hit_mem_a", mem_a, a_before);
      end else begin
        for (int k = 0; k < 4; k++)
          check_eq("mem_a_seq", trace[n - 6 + k], a + 32'(k));
      end
    end
    if (!hit) begin
      buf_valid = 1'b1;
      buf_tag   = a;
      buf_word  = exp_w;
    end
    last_data = exp_w;
  endtask

  task automatic release_req();
    ram_read = 1'b0;
    tick();
    check_eq("ready_pulse", {31'd0, ram_ready}, 32'd0);
    check_eq("data_hold", ram_data, last_data);
    check_eq("mem_wr", {31'd0, mem_wr}, 32'd0);
  endtask

  task automatic abort_req(input logic [31:0] a, input int k);
    bit seen;
    seen     = 1'b0;
    ram_read = 1'b1;
    ram_addr = a;
    repeat (k) begin
      tick();
      seen |= ram_ready;
    end
    ram_read = 1'b0;
    repeat (7) begin
      tick();
      seen |= ram_ready;
    end
    check_eq("abort_no_ready", {31'd0, seen}, 32'd0);
    check_eq("abort_data_hold", ram_data, last_data);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready"}, {31'd0, ram_ready}, 32'd0);
    check_eq({tag, "_data"}, ram_data, 32'd0);
    check_eq({tag, "_mem_a"}, mem_a, 32'd0);
    check_eq({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_reset_state("reset");
    buf_valid = 1'b0;
    last_data = 32'd0;
    ram_read  = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] prev_a;
    bit          seen;
    int          mode;
    reset     = 1'b0;
    ram_read  = 1'b0;
    ram_addr  = 32'd0;
    buf_valid = 1'b0;
    buf_tag   = 32'd0;
    buf_word  = 32'd0;
    last_data = 32'd0;
    mem[32'h100] = 8'h13;
    mem[32'h101] = 8'h00;
    mem[32'h102] = 8'h50;
    mem[32'h103] = 8'h00;
    for (int i = 0; i < 4; i++) mem[32'h104 + 32'(i)] = 8'(8'hA0 + 8'(i));

    do_reset();

    fetch(32'h100, 0, 1'b1);
    check_eq("word_0x100", ram_data, 32'h00500013);
    // Re-request raised during the DONE cycle.
    fetch(32'h104, 1, 1'b1);
    check_eq("word_0x104", ram_data, 32'hA3A2A1A0);
    release_req();

    // Redirect from 0x200 to 0x300 while in RD1.
    ram_read = 1'b1;
    ram_addr = 32'h200;
    seen     = 1'b0;
    repeat (3) begin
      tick();
      seen |= ram_ready;
    end
    check_eq("redirect_no_ready", {31'd0, seen}, 32'd0);
    fetch(32'h300, 0, 1'b0);
    release_req();

    fetch(32'hFFFF_FFFE, 0, 1'b1);
    release_req();

    // Async reset asserted in RD2.
    ram_read = 1'b1;
    ram_addr = 32'h500;
    repeat (4) tick();
    do_reset();
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= ram_ready;
    end
    check_eq("post_reset_no_ready", {31'd0, seen}, 32'd0);

    // Repeated fetch (buffer hit when enabled), then cold after reset.
    fetch(32'h40, 0, 1'b1);
    release_req();
    fetch(32'h40, 0, 1'b1);
    release_req();
    do_reset();
    fetch(32'h40, 0, 1'b1);
    release_req();

    prev_a = 32'h40;
    for (int it = 0; it < 30; it++) begin
      a = ($urandom_range(0, 3) == 0) ? prev_a : $urandom;
      repeat ($urandom_range(0, 2)) tick();
      mode = $urandom_range(0, 2);
      if (mode == 0 && !model_hit(a)) begin
        abort_req(a, $urandom_range(1, 5));
      end else begin
        fetch(a, 0, 1'b1);
        if (mode == 2) begin
          prev_a = a;
          a = ($urandom_range(0, 1) == 0) ? prev_a : $urandom;
          fetch(a, 1, 1'b1);
        end
        release_req();
      end
      prev_a = a;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
